// File: rtl/cam_cfg_pkg.sv
// Shared types and constants for the camera configuration sequencer:
// FSM state encoding, table entry layout, marker codes and sensor registers.
package cam_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_DELAY  = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERROR  = 3'd7
  } cfg_state_t;

  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] reg_data;
  } cfg_entry_t;

  // Table markers
  localparam logic [7:0] CFG_END_REG   = 8'hFF;
  localparam logic [7:0] CFG_END_DATA  = 8'hFF;
  localparam logic [7:0] CFG_DELAY_REG = 8'hFE;

  // Sensor register addresses
  localparam logic [7:0] REG_CLKRC  = 8'h11;
  localparam logic [7:0] REG_COM7   = 8'h12;
  localparam logic [7:0] REG_COM15  = 8'h40;
  localparam logic [7:0] REG_RGB444 = 8'h8C;

  // Sensor register values used by the default table
  localparam logic [7:0] COM7_RESET      = 8'h80;
  localparam logic [7:0] COM7_QVGA_RGB   = 8'h14;
  localparam logic [7:0] COM15_RGB565    = 8'hD0;
  localparam logic [7:0] RGB444_OFF      = 8'h00;
  localparam logic [7:0] CLKRC_DIV2      = 8'h01;
  localparam logic [7:0] RESET_SETTLE_MS = 8'd10;

  function automatic logic is_end(input cfg_entry_t e);
    return (e.reg_addr == CFG_END_REG) && (e.reg_data == CFG_END_DATA);
  endfunction

  function automatic logic is_delay(input cfg_entry_t e);
    return (e.reg_addr == CFG_DELAY_REG);
  endfunction

endpackage

// File: rtl/cam_config_rom.sv
// Camera configuration table: synchronous read, one cycle from index to entry.
// Unlisted slots read as END so a short table never runs into garbage.
module cam_config_rom
  import cam_cfg_pkg::*;
#(
  parameter int ROM_AW = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ROM_AW-1:0] index,
  output logic [15:0]       entry
);

  logic [15:0] rom_word_s;

  // Table contents: sensor soft reset, settle delay, RGB565/QVGA setup, END.
  always_comb begin
    rom_word_s = {CFG_END_REG, CFG_END_DATA};
    case (index)
      ROM_AW'(0): rom_word_s = {REG_COM7,      COM7_RESET};
      ROM_AW'(1): rom_word_s = {CFG_DELAY_REG, RESET_SETTLE_MS};
      ROM_AW'(2): rom_word_s = {REG_CLKRC,     CLKRC_DIV2};
      ROM_AW'(3): rom_word_s = {REG_COM7,      COM7_QVGA_RGB};
      ROM_AW'(4): rom_word_s = {REG_COM15,     COM15_RGB565};
      ROM_AW'(5): rom_word_s = {REG_RGB444,    RGB444_OFF};
      ROM_AW'(6): rom_word_s = {CFG_END_REG,   CFG_END_DATA};
      default:    rom_word_s = {CFG_END_REG,   CFG_END_DATA};
    endcase
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      entry <= 16'h0000;
    end else begin
      entry <= rom_word_s;
    end
  end

endmodule

// File: rtl/cam_config_sequencer.sv
// Camera configuration sequencer: on request from the top-level controller,
// walks the register table, issues each write to the SCCB master, honours
// delay entries, retries NACKed writes and reports sticky done / error.
module cam_config_sequencer
  import cam_cfg_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int ROM_AW      = 6,
  parameter int MAX_RETRIES = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_config_start,
  output logic              o_config_done,
  output logic              o_config_error,
  output logic              o_wr_valid,
  output logic [7:0]        o_wr_reg,
  output logic [7:0]        o_wr_data,
  input  logic              i_wr_ready,
  input  logic              i_wr_done,
  input  logic              i_wr_nack,
  output logic [ROM_AW-1:0] o_rom_index
);

  // Slow test clocks still get at least one tick per millisecond.
  localparam int TICKS_PER_MS = (CLK_FREQ_HZ >= 1000) ? (CLK_FREQ_HZ / 1000) : 1;
  localparam int TW           = $clog2(TICKS_PER_MS + 1);
  localparam logic [TW-1:0]     TICK_LAST   = TW'(TICKS_PER_MS - 1);
  localparam logic [7:0]        RETRY_LIMIT = 8'(MAX_RETRIES);
  localparam logic [ROM_AW-1:0] INDEX_LAST  = {ROM_AW{1'b1}};

  cfg_state_t        state_r, state_s;
  logic [ROM_AW-1:0] index_r, index_s;
  logic [7:0]        retry_r, retry_s;
  logic [TW-1:0]     tick_r, tick_s;
  logic [7:0]        ms_r, ms_s;
  logic [7:0]        wr_reg_r, wr_reg_s;
  logic [7:0]        wr_data_r, wr_data_s;
  logic              wr_valid_r;
  logic              done_r;
  logic              error_r;
  logic              start_d_r;

  logic [15:0]       rom_word_s;
  cfg_entry_t        entry_s;
  logic              entry_end_s;

  cam_config_rom #(
    .ROM_AW (ROM_AW)
  ) u_rom (
    .clk   (i_clk),
    .reset (i_reset),
    .index (index_r),
    .entry (rom_word_s)
  );

  assign entry_s = cfg_entry_t'(rom_word_s);
  // The last slot is always END so the index can never wrap back to 0.
  assign entry_end_s = is_end(entry_s) || (index_r == INDEX_LAST);

  // Next-state and datapath update logic.
  always_comb begin
    state_s   = state_r;
    index_s   = index_r;
    retry_s   = retry_r;
    tick_s    = tick_r;
    ms_s      = ms_r;
    wr_reg_s  = wr_reg_r;
    wr_data_s = wr_data_r;
    case (state_r)
      ST_IDLE: begin
        if (i_config_start && !done_r && !error_r) begin
          state_s = ST_FETCH;
          index_s = {ROM_AW{1'b0}};
          retry_s = 8'h00;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_s = ST_DECODE;
      end
      ST_DECODE: begin
        if (entry_end_s) begin
          state_s = ST_DONE;
        end else if (is_delay(entry_s)) begin
          state_s = ST_DELAY;
          tick_s  = {TW{1'b0}};
          ms_s    = 8'h00;
        end else begin
          state_s   = ST_ISSUE;
          wr_reg_s  = entry_s.reg_addr;
          wr_data_s = entry_s.reg_data;
        end
      end
      ST_ISSUE: begin
        // A done pulse coinciding with acceptance is not ours; ignore it.
        if (i_wr_ready) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (i_wr_done) begin
          if (!i_wr_nack) begin
            state_s = ST_FETCH;
            index_s = index_r + ROM_AW'(1);
            retry_s = 8'h00;
          end else if (retry_r < RETRY_LIMIT) begin
            state_s = ST_ISSUE;
            retry_s = retry_r + 8'd1;
          end else begin
            state_s = ST_ERROR;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DELAY: begin
        // Entry stays valid here: the index does not move during a delay.
        if (ms_r == entry_s.reg_data) begin
          state_s = ST_FETCH;
          index_s = index_r + ROM_AW'(1);
          tick_s  = {TW{1'b0}};
          ms_s    = 8'h00;
        end else if (tick_r == TICK_LAST) begin
          tick_s = {TW{1'b0}};
          ms_s   = ms_r + 8'd1;
        end else begin
          tick_s = tick_r + TW'(1);
        end
      end
      ST_DONE: begin
        // Only a fresh rising edge of the request replays the table.
        if (i_config_start && !start_d_r) begin
          state_s = ST_FETCH;
          index_s = {ROM_AW{1'b0}};
          retry_s = 8'h00;
        end else begin
          state_s = ST_DONE;
        end
      end
      ST_ERROR: begin
        state_s = ST_ERROR;
      end
      default: begin
        state_s = ST_IDLE;
        index_s = {ROM_AW{1'b0}};
        retry_s = 8'h00;
      end
    endcase
  end

  // State, datapath and registered outputs; reset aborts any transaction.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r    <= ST_IDLE;
      index_r    <= {ROM_AW{1'b0}};
      retry_r    <= 8'h00;
      tick_r     <= {TW{1'b0}};
      ms_r       <= 8'h00;
      wr_reg_r   <= 8'h00;
      wr_data_r  <= 8'h00;
      wr_valid_r <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      start_d_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      index_r    <= index_s;
      retry_r    <= retry_s;
      tick_r     <= tick_s;
      ms_r       <= ms_s;
      wr_reg_r   <= wr_reg_s;
      wr_data_r  <= wr_data_s;
      wr_valid_r <= (state_s == ST_ISSUE);
      done_r     <= (state_s == ST_DONE);
      error_r    <= (state_s == ST_ERROR);
      start_d_r  <= i_config_start;
    end
  end

  assign o_config_done  = done_r;
  assign o_config_error = error_r;
  assign o_wr_valid     = wr_valid_r;
  assign o_wr_reg       = wr_reg_r;
  assign o_wr_data      = wr_data_r;
  assign o_rom_index    = index_r;

endmodule

// File: tb/tb_cam_config_sequencer.sv
// Directed bench for cam_config_sequencer against its default table
// {12/80, FE/0A, 11/01, 12/14, 40/D0, 8C/00, END}, 2 ticks per ms.
module tb_cam_config_sequencer;

  localparam int CLK_FREQ_HZ = 2000;
  localparam int ROM_AW      = 6;
  localparam int MAX_RETRIES = 3;
  localparam logic [15:0] EXP_W [0:4] = '{16'h1280, 16'h1101, 16'h1214, 16'h40D0, 16'h8C00};

  logic              clk = 1'b0;
  logic              i_reset;
  logic              i_config_start;
  logic              o_config_done;
  logic              o_config_error;
  logic              o_wr_valid;
  logic [7:0]        o_wr_reg;
  logic [7:0]        o_wr_data;
  logic              i_wr_ready;
  logic              i_wr_done;
  logic              i_wr_nack;
  logic [ROM_AW-1:0] o_rom_index;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int done_cnt    = 0;
  int nack_left   = 0;
  int stall_left  = 0;
  bit model_en    = 1'b1;
  logic [15:0] log_w[$];
  int          log_cyc[$];

  cam_config_sequencer #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .ROM_AW      (ROM_AW),
    .MAX_RETRIES (MAX_RETRIES)
  ) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_config_start (i_config_start),
    .o_config_done  (o_config_done),
    .o_config_error (o_config_error),
    .o_wr_valid     (o_wr_valid),
    .o_wr_reg       (o_wr_reg),
    .o_wr_data      (o_wr_data),
    .i_wr_ready     (i_wr_ready),
    .i_wr_done      (i_wr_done),
    .i_wr_nack      (i_wr_nack),
    .o_rom_index    (o_rom_index)
  );

  always #5 clk = ~clk;

  // One cycle at the negedge: SCCB master model (ready unless stalled,
  // done five cycles after acceptance, scripted NACKs) plus request log.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (model_en) begin
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) begin
          i_wr_done = 1'b1;
          i_wr_nack = (nack_left > 0);
          if (nack_left > 0) nack_left--;
        end else begin
          i_wr_done = 1'b0;
          i_wr_nack = 1'b0;
        end
      end else begin
        i_wr_done = 1'b0;
        i_wr_nack = 1'b0;
      end
      if (stall_left > 0) begin
        i_wr_ready = 1'b0;
        stall_left--;
      end else begin
        i_wr_ready = 1'b1;
      end
      if (o_wr_valid && i_wr_ready) begin
        log_w.push_back({o_wr_reg, o_wr_data});
        log_cyc.push_back(cyc);
        done_cnt = 5;
      end
    end
  endtask

  function automatic logic [15:0] log_at(input int i);
    if (i < log_w.size()) return log_w[i];
    else return 16'hxxxx;
  endfunction

  function automatic int cyc_at(input int i);
    if (i < log_cyc.size()) return log_cyc[i];
    else return -1000;
  endfunction

  task automatic run_until_done(input int budget);
    int n = 0;
    while (!o_config_done && !o_config_error && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    i_config_start = 1'b0;
    i_wr_ready = 1'b1;
    i_wr_done = 1'b0;
    i_wr_nack = 1'b0;
    model_en = 1'b1;
    done_cnt = 0;
    nack_left = 0;
    stall_left = 0;
    for (int k = 0; k < 3; k++) tick();
    i_reset = 1'b0;
    tick();
    log_w.delete();
    log_cyc.delete();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (o_wr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", o_wr_valid); end
    vectors++; if (o_config_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", o_config_done); end
    vectors++; if (o_config_error !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %b expected 0", o_config_error); end
    vectors++; if (o_wr_reg !== 8'h00) begin miscompares++; $display("FAIL reset_reg: got %h expected 00", o_wr_reg); end
    vectors++; if (o_wr_data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h expected 00", o_wr_data); end
    vectors++; if (o_rom_index !== 6'd0) begin miscompares++; $display("FAIL reset_index: got %0d expected 0", o_rom_index); end
  endtask

  task automatic test_nominal();
    int c0;
    logic [15:0] exp;
    c0 = cyc;
    i_config_start = 1'b1;
    run_until_done(300);
    vectors++; if (o_config_done !== 1'b1) begin miscompares++; $display("FAIL nominal_done: got %b expected 1", o_config_done); end
    vectors++; if (o_config_error !== 1'b0) begin miscompares++; $display("FAIL nominal_error: got %b expected 0", o_config_error); end
    vectors++; if (log_w.size() != 5) begin miscompares++; $display("FAIL nominal_count: got %0d expected 5", log_w.size()); end
    for (int i = 0; i < 5; i++) begin
      exp = EXP_W[i];
      vectors++; if (log_at(i) !== exp) begin miscompares++; $display("FAIL nominal_write%0d: got %h expected %h", i, log_at(i), exp); end
    end
    // IDLE, FETCH, DECODE -> first request 3 cycles after start
    vectors++; if (cyc_at(0) - c0 != 3) begin miscompares++; $display("FAIL first_latency: got %0d expected 3", cyc_at(0) - c0); end
    // 3 + 5 (done) + 1 (WAIT) + 2 (FETCH,DECODE) + 10ms*2+1 (DELAY) + 2 (FETCH,DECODE) = 34
    vectors++; if (cyc_at(1) - c0 != 34) begin miscompares++; $display("FAIL delay_latency: got %0d expected 34", cyc_at(1) - c0); end
    // last write at 58, done at 63, FETCH 64, DECODE 65, DONE 66
    vectors++; if (cyc - c0 != 66) begin miscompares++; $display("FAIL done_latency: got %0d expected 66", cyc - c0); end
    vectors++; if (o_rom_index !== 6'd6) begin miscompares++; $display("FAIL done_index: got %0d expected 6", o_rom_index); end
    for (int k = 0; k < 20; k++) tick();
    vectors++; if (log_w.size() != 5) begin miscompares++; $display("FAIL no_extra_writes: got %0d expected 5", log_w.size()); end
    vectors++; if (o_config_done !== 1'b1) begin miscompares++; $display("FAIL done_held: got %b expected 1", o_config_done); end
  endtask

  task automatic test_done_restart();
    int c0;
    i_config_start = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    vectors++; if (o_config_done !== 1'b1) begin miscompares++; $display("FAIL done_sticky: got %b expected 1", o_config_done); end
    vectors++; if (log_w.size() != 5) begin miscompares++; $display("FAIL idle_after_drop: got %0d writes expected 5", log_w.size()); end
    log_w.delete();
    log_cyc.delete();
    c0 = cyc;
    i_config_start = 1'b1;
    tick();
    vectors++; if (o_config_done !== 1'b0) begin miscompares++; $display("FAIL restart_clears_done: got %b expected 0", o_config_done); end
    run_until_done(300);
    vectors++; if (log_at(0) !== 16'h1280) begin miscompares++; $display("FAIL replay_first: got %h expected 1280", log_at(0)); end
    vectors++; if (cyc_at(0) - c0 != 3) begin miscompares++; $display("FAIL replay_latency: got %0d expected 3", cyc_at(0) - c0); end
    vectors++; if (log_w.size() != 5) begin miscompares++; $display("FAIL replay_count: got %0d expected 5", log_w.size()); end
    vectors++; if (o_config_done !== 1'b1) begin miscompares++; $display("FAIL replay_done: got %b expected 1", o_config_done); end
  endtask

  task automatic test_ready_stall();
    int c0;
    do_reset();
    stall_left = 6;
    c0 = cyc;
    i_config_start = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    vectors++; if ({o_wr_valid, o_wr_reg, o_wr_data} !== 17'h11280) begin miscompares++; $display("FAIL stall_hold: got v=%b %h/%h expected v=1 12/80", o_wr_valid, o_wr_reg, o_wr_data); end
    vectors++; if (log_w.size() != 0) begin miscompares++; $display("FAIL stall_no_accept: got %0d expected 0", log_w.size()); end
    run_until_done(300);
    vectors++; if (cyc_at(0) - c0 != 7) begin miscompares++; $display("FAIL stall_accept_cycle: got %0d expected 7", cyc_at(0) - c0); end
    vectors++; if (log_w.size() != 5 || o_config_done !== 1'b1) begin miscompares++; $display("FAIL stall_complete: got %0d writes done=%b expected 5 done=1", log_w.size(), o_config_done); end
  endtask

  task automatic test_nack_retry();
    do_reset();
    nack_left = 2;
    i_config_start = 1'b1;
    run_until_done(400);
    vectors++; if (log_w.size() != 7) begin miscompares++; $display("FAIL retry_count: got %0d expected 7", log_w.size()); end
    for (int i = 0; i < 3; i++) begin
      vectors++; if (log_at(i) !== 16'h1280) begin miscompares++; $display("FAIL retry_same%0d: got %h expected 1280", i, log_at(i)); end
    end
    vectors++; if (log_at(3) !== 16'h1101) begin miscompares++; $display("FAIL retry_advance: got %h expected 1101", log_at(3)); end
    // NACK seen in WAIT goes straight back to ISSUE: 5 + 1 cycles apart
    vectors++; if (cyc_at(1) - cyc_at(0) != 6) begin miscompares++; $display("FAIL retry_gap: got %0d expected 6", cyc_at(1) - cyc_at(0)); end
    vectors++; if ({o_config_done, o_config_error} !== 2'b10) begin miscompares++; $display("FAIL retry_flags: got %b expected 10", {o_config_done, o_config_error}); end
    vectors++; if (o_rom_index !== 6'd6) begin miscompares++; $display("FAIL retry_index: got %0d expected 6", o_rom_index); end
  endtask

  task automatic test_nack_error();
    int c0;
    do_reset();
    nack_left = 4;
    c0 = cyc;
    i_config_start = 1'b1;
    run_until_done(400);
    vectors++; if (log_w.size() != 4) begin miscompares++; $display("FAIL error_count: got %0d expected 4", log_w.size()); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (log_at(i) !== 16'h1280) begin miscompares++; $display("FAIL error_req%0d: got %h expected 1280", i, log_at(i)); end
    end
    // requests at 3,9,15,21; fourth NACK at 26, ERROR visible at 27
    vectors++; if (cyc - c0 != 27) begin miscompares++; $display("FAIL error_latency: got %0d expected 27", cyc - c0); end
    vectors++; if ({o_config_done, o_config_error, o_wr_valid} !== 3'b010) begin miscompares++; $display("FAIL error_flags: got %b expected 010", {o_config_done, o_config_error, o_wr_valid}); end
    i_config_start = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    i_config_start = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    i_config_start = 1'b0;
    for (int k = 0; k < 2; k++) tick();
    i_config_start = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    vectors++; if (log_w.size() != 4) begin miscompares++; $display("FAIL error_toggle_writes: got %0d expected 4", log_w.size()); end
    vectors++; if ({o_config_done, o_config_error} !== 2'b01) begin miscompares++; $display("FAIL error_sticky: got %b expected 01", {o_config_done, o_config_error}); end
    vectors++; if (o_rom_index !== 6'd0) begin miscompares++; $display("FAIL error_index: got %0d expected 0", o_rom_index); end
  endtask

  task automatic test_reset_in_wait();
    int c0;
    bit saw_valid;
    do_reset();
    c0 = cyc;
    i_config_start = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    vectors++; if ({o_wr_valid, o_wr_reg} !== 9'h012) begin miscompares++; $display("FAIL wait_entry: got v=%b reg=%h expected v=0 reg=12", o_wr_valid, o_wr_reg); end
    i_reset = 1'b1;
    i_config_start = 1'b0;
    model_en = 1'b0;
    done_cnt = 0;
    i_wr_done = 1'b0;
    i_wr_nack = 1'b0;
    tick();
    vectors++; if ({o_wr_valid, o_config_done, o_config_error, o_wr_reg, o_wr_data, o_rom_index} !== 25'h0) begin
      miscompares++;
      $display("FAIL reset_in_wait: got v=%b d=%b e=%b %h/%h idx=%0d expected all 0", o_wr_valid, o_config_done, o_config_error, o_wr_reg, o_wr_data, o_rom_index);
    end
    i_reset = 1'b0;
    tick();
    i_wr_done = 1'b1;
    tick();
    i_wr_done = 1'b0;
    saw_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (o_wr_valid) saw_valid = 1'b1;
    end
    vectors++; if (saw_valid !== 1'b0) begin miscompares++; $display("FAIL stray_done: got valid=%b expected 0", saw_valid); end
    vectors++; if ({o_config_done, o_config_error} !== 2'b00) begin miscompares++; $display("FAIL stray_flags: got %b expected 00", {o_config_done, o_config_error}); end
    model_en = 1'b1;
    log_w.delete();
    log_cyc.delete();
    c0 = cyc;
    i_config_start = 1'b1;
    run_until_done(300);
    vectors++; if (log_at(0) !== 16'h1280 || cyc_at(0) - c0 != 3) begin miscompares++; $display("FAIL post_reset_restart: got %h at %0d expected 1280 at 3", log_at(0), cyc_at(0) - c0); end
    vectors++; if (log_w.size() != 5 || o_config_done !== 1'b1) begin miscompares++; $display("FAIL post_reset_complete: got %0d writes done=%b expected 5 done=1", log_w.size(), o_config_done); end
  endtask

  initial begin
    i_reset = 1'b1;
    i_config_start = 1'b0;
    i_wr_ready = 1'b1;
    i_wr_done = 1'b0;
    i_wr_nack = 1'b0;
    test_reset();
    test_nominal();
    test_done_restart();
    test_ready_stall();
    test_nack_retry();
    test_nack_error();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
